urp_pcie_tlp_rr_scheduler: RTL and testbench
============================================

Name: urp_pcie_tlp_rr_scheduler

Overview:
- Packet-locked round-robin scheduler that shares one 32-bit TLP word stream toward the RX transaction layer among N_SRC sources, such as the per-buffer TLP FIFOs.
- Once a source wins, it keeps the grant until it delivers its last word, so TLPs are never interleaved.
- Admission is gated by a header-credit counter replenished by downstream credit returns.
- A length watchdog flags and terminates runaway packets.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- DATA_WIDTH, 32, word width.
- CREDIT_MAX, 4, header credits after reset and saturation ceiling (1..15).
- MAX_WORDS, 7, maximum words per TLP; the 224-bit TLP is 7 words.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- src_valid_i  input  N_SRC  per-source word valid.
- src_last_i  input  N_SRC  per-source last-word flag, qualified by valid.
- src_data_i  input  N_SRC*DATA_WIDTH  packed words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready_o  output  N_SRC  per-source ready.
- dst_valid_o  output  1  output word valid.
- dst_last_o  output  1  output last word.
- dst_data_o  output  DATA_WIDTH  output word.
- dst_ready_i  input  1  downstream ready.
- credit_return_i  input  1  one-cycle pulse returning one header credit.
- grant_o  output  N_SRC  one-hot current owner; 0 when idle.
- busy_o  output  1  high in XFER.
- credit_cnt_o  output  4  available credits.
- len_err_o  output  1  sticky length-violation flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Sampled only on a rising clk edge with rst_n=0.
  - Reset applies even mid-packet: the in-flight packet is abandoned and no flush is performed.
- Reset values:
  - state=IDLE, grant_o=0, busy_o=0.
  - dst_valid_o=0, dst_last_o=0, dst_data_o=0, src_ready_o=0.
  - credit_cnt_o=CREDIT_MAX, len_err_o=0.
  - word counter=0; last_grant pointer=N_SRC-1, so source 0 has first priority.
- States: IDLE, XFER.
- IDLE:
  - All src_ready_o=0 and dst_valid_o=0.
  - If any src_valid_i and credit_cnt_o>0: select the first valid source scanning from last_grant+1 upward, wrapping modulo N_SRC.
  - Register the selection into grant_o and last_grant, decrement credits, and go to XFER.
  - The arbitration cycle transfers no data (one-cycle bubble per packet).
  - If credit_cnt_o==0, stay in IDLE regardless of requests.
- XFER, with g = granted index:
  - Pass-through is purely combinational: dst_valid_o=src_valid_i[g], dst_data_o=src_data_i[g], dst_last_o=src_last_i[g].
  - src_ready_o[g]=dst_ready_i; all other ready bits are 0.
  - Handshake = dst_valid_o & dst_ready_i. On each handshake the word counter increments (width clog2(MAX_WORDS+1)).
  - Handshake with dst_last_o=1: return to IDLE, clear counter and grant_o.
  - Handshake where the counter reaches MAX_WORDS with last=0: force dst_last_o=1 on that word, set len_err_o, return to IDLE.
  - The source's remaining words are then arbitrated as a new packet.
  - Source valid dropping mid-packet: grant held, no timeout.
- Credits:
  - Grant alone: -1.
  - credit_return_i alone: +1, except at CREDIT_MAX where the return is ignored.
  - Both in the same cycle: unchanged.
  - The counter never underflows, because grants require credit>0.
- len_err_o clears only on reset.
- Back-to-back packets from the same source are allowed when it is the only requester. Fairness is round-robin at packet granularity.
- Latency: first word is available the cycle after the request is seen in IDLE; zero added latency per word thereafter.

Test Plan:
- Single packet:
  - Stimulus: reset, src0 sends 7 words 0x11..0x17 with last on word 7, dst_ready_i=1.
  - Required: grant_o=01 one cycle after valid; 7 consecutive dst words 0x11..0x17 with dst_last_o on 0x17; credit_cnt_o 4→3; back to IDLE.
- Round-robin fairness:
  - Stimulus: src0 and src1 both continuously request 7-word packets.
  - Required: grant order 0,1,0,1; no interleaving within a packet; credits reach 0 after 4 packets and the scheduler stalls in IDLE.
- Credit flow:
  - Stimulus: credits=0, then one credit_return_i pulse.
  - Required: exactly one packet is admitted.
  - Stimulus: grant and credit return in the same cycle. Required: count unchanged.
  - Stimulus: 3 returns at count 4. Required: stays 4.
- Backpressure:
  - Stimulus: dst_ready_i toggles 1,0,1,0 during a packet.
  - Required: src_ready_o[g] mirrors dst_ready_i; words are neither duplicated nor lost; counter advances only on handshakes.
- Length watchdog:
  - Stimulus: src1 sends 9 words with no last.
  - Required: word 7 is emitted with dst_last_o=1; len_err_o=1 and stays high; the remaining 2 words are re-arbitrated as a new packet after a bubble and consume a credit.
- Reset mid-packet:
  - Stimulus: rst_n=0 for one edge after word 3.
  - Required: next cycle grant_o=0, dst_valid_o=0, credit_cnt_o=4, len_err_o=0; the next arbitration starts from source 0.

Source files
------------

// File: rtl/urp_pcie_tlp_rr_scheduler.sv
// ---------------------------------------------------------------------------
// urp_pcie_tlp_rr_scheduler
//
// Packet-locked round-robin scheduler. Merges N_SRC word streams (for example,
// the per-buffer TLP FIFOs) into a single TLP word stream toward the RX
// transaction layer. A winning source keeps the grant until its last word is
// accepted, so TLPs are never interleaved. A header-credit counter gates
// admission. A length watchdog ends runaway packets after MAX_WORDS words and
// sets a sticky error flag.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   src_valid_i     per-source word valid
//   src_last_i      per-source last-word flag (qualified by valid)
//   src_data_i      packed source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready_o     per-source ready (only the granted source sees dst_ready_i)
//   dst_valid_o     output word valid
//   dst_last_o      output last word (forced high on a watchdog cut)
//   dst_data_o      output word
//   dst_ready_i     downstream ready
//   credit_return_i one-cycle pulse returning one header credit
//   grant_o         one-hot current owner, 0 when idle
//   busy_o          high while a packet is being transferred
//   credit_cnt_o    available header credits
//   len_err_o       sticky length-violation flag
// ---------------------------------------------------------------------------
module urp_pcie_tlp_rr_scheduler #(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CREDIT_MAX = 4,
    parameter int MAX_WORDS  = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SRC-1:0]            src_valid_i,
    input  logic [N_SRC-1:0]            src_last_i,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_data_i,
    output logic [N_SRC-1:0]            src_ready_o,
    output logic                        dst_valid_o,
    output logic                        dst_last_o,
    output logic [DATA_WIDTH-1:0]       dst_data_o,
    input  logic                        dst_ready_i,
    input  logic                        credit_return_i,
    output logic [N_SRC-1:0]            grant_o,
    output logic                        busy_o,
    output logic [3:0]                  credit_cnt_o,
    output logic                        len_err_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [3:0]       CREDIT_INIT = 4'(CREDIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_SRC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last_grant;
    logic [3:0]         r_credit;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_len_err;

    state_t             w_state_next;
    logic [N_SRC-1:0]   w_grant_next;
    logic [IDX_W-1:0]   w_gidx_next;
    logic [IDX_W-1:0]   w_last_grant_next;
    logic [3:0]         w_credit_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_len_err_next;
    logic               w_do_grant;

    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;

    logic               w_g_valid;
    logic               w_g_last;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic               w_at_limit;
    logic               w_end_pkt;
    logic               w_hs;

    // Round-robin pick: first valid source strictly after the last winner, wrapping.
    always_comb begin
        logic             v_found;
        logic [IDX_W-1:0] v_pick;
        logic [IDX_W-1:0] v_cand;
        logic             v_hit;
        v_found = 1'b0;
        v_pick  = '0;
        v_cand  = '0;
        v_hit   = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            v_cand  = IDX_W'((int'(r_last_grant) + k) % N_SRC);
            v_hit   = src_valid_i[v_cand] & ~v_found;
            v_pick  = v_hit ? v_cand : v_pick;
            v_found = v_found | v_hit;
        end
        w_pick_found = v_found;
        w_pick_idx   = v_pick;
    end

    // Selects the granted source's word and handshake qualifiers.
    always_comb begin
        w_g_valid  = src_valid_i[r_gidx];
        w_g_last   = src_last_i[r_gidx];
        w_g_data   = src_data_i[r_gidx*DATA_WIDTH +: DATA_WIDTH];
        // The word that would become word number MAX_WORDS gets cut.
        w_at_limit = (r_cnt == CNT_LIMIT);
        w_end_pkt  = w_g_last | w_at_limit;
        w_hs       = (r_state == ST_XFER) & w_g_valid & dst_ready_i;
    end

    // FSM next-state logic and combinational pass-through outputs.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_gidx_next       = r_gidx;
        w_last_grant_next = r_last_grant;
        w_cnt_next        = r_cnt;
        w_len_err_next    = r_len_err;
        w_do_grant        = 1'b0;
        dst_valid_o       = 1'b0;
        dst_last_o        = 1'b0;
        dst_data_o        = '0;
        src_ready_o       = '0;
        case (r_state)
            ST_IDLE: begin
                // Arbitration cycle moves no data; it costs one bubble per packet.
                if (w_pick_found && (r_credit != 4'd0)) begin
                    w_do_grant        = 1'b1;
                    w_state_next      = ST_XFER;
                    w_gidx_next       = w_pick_idx;
                    w_last_grant_next = w_pick_idx;
                    w_grant_next      = N_SRC'(1) << w_pick_idx;
                    w_cnt_next        = '0;
                end else begin
                    w_state_next      = ST_IDLE;
                end
            end
            ST_XFER: begin
                dst_valid_o          = w_g_valid;
                dst_data_o           = w_g_data;
                dst_last_o           = w_end_pkt;
                src_ready_o[r_gidx]  = dst_ready_i;
                if (w_hs) begin
                    if (w_end_pkt) begin
                        w_state_next   = ST_IDLE;
                        w_grant_next   = '0;
                        w_cnt_next     = '0;
                        w_len_err_next = r_len_err | (w_at_limit & ~w_g_last);
                    end else begin
                        w_cnt_next     = r_cnt + CNT_W'(1);
                    end
                end else begin
                    // Stalled source or sink: hold the grant indefinitely.
                    w_state_next = ST_XFER;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Header credit accounting; a grant and a return in the same cycle cancel.
    always_comb begin
        case ({w_do_grant, credit_return_i})
            2'b10:   w_credit_next = r_credit - 4'd1;
            2'b01:   w_credit_next = (r_credit == CREDIT_INIT) ? r_credit : (r_credit + 4'd1);
            default: w_credit_next = r_credit;
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= IDX_LAST;
            r_credit     <= CREDIT_INIT;
            r_cnt        <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_gidx       <= w_gidx_next;
            r_last_grant <= w_last_grant_next;
            r_credit     <= w_credit_next;
            r_cnt        <= w_cnt_next;
            r_len_err    <= w_len_err_next;
        end
    end

    assign grant_o      = r_grant;
    assign busy_o       = (r_state == ST_XFER);
    assign credit_cnt_o = r_credit;
    assign len_err_o    = r_len_err;

endmodule

// File: tb/tb_urp_pcie_tlp_rr_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for urp_pcie_tlp_rr_scheduler (N_SRC=2, 32-bit words).
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 unit
// later, so a check sees the combinational outputs for the current inputs and
// the registers updated at the previous edge.
// ---------------------------------------------------------------------------
module tb_urp_pcie_tlp_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  src_valid_i;
    logic [1:0]  src_last_i;
    logic [63:0] src_data_i;
    logic [1:0]  src_ready_o;
    logic        dst_valid_o;
    logic        dst_last_o;
    logic [31:0] dst_data_o;
    logic        dst_ready_i;
    logic        credit_return_i;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic [3:0]  credit_cnt_o;
    logic        len_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    urp_pcie_tlp_rr_scheduler #(
        .N_SRC(2), .DATA_WIDTH(32), .CREDIT_MAX(4), .MAX_WORDS(7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid_i), .src_last_i(src_last_i), .src_data_i(src_data_i),
        .src_ready_o(src_ready_o),
        .dst_valid_o(dst_valid_o), .dst_last_o(dst_last_o), .dst_data_o(dst_data_o),
        .dst_ready_i(dst_ready_i), .credit_return_i(credit_return_i),
        .grant_o(grant_o), .busy_o(busy_o), .credit_cnt_o(credit_cnt_o),
        .len_err_o(len_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, then settle for checking.
    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [31:0] d0,
                         input logic [31:0] d1, input logic rdy, input logic cret);
        @(posedge clk);
        #1;
        src_valid_i     = v;
        src_last_i      = l;
        src_data_i      = {d1, d0};
        dst_ready_i     = rdy;
        credit_return_i = cret;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        src_valid_i     = 2'b00;
        src_last_i      = 2'b00;
        src_data_i      = 64'd0;
        dst_ready_i     = 1'b0;
        credit_return_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_grant"},  32'(grant_o),      32'd0);
        check_eq({tag, "_busy"},   32'(busy_o),       32'd0);
        check_eq({tag, "_dvalid"}, 32'(dst_valid_o),  32'd0);
        check_eq({tag, "_dlast"},  32'(dst_last_o),   32'd0);
        check_eq({tag, "_ddata"},  dst_data_o,        32'd0);
        check_eq({tag, "_sready"}, 32'(src_ready_o),  32'd0);
        check_eq({tag, "_credit"}, 32'(credit_cnt_o), 32'd4);
        check_eq({tag, "_lenerr"}, 32'(len_err_o),    32'd0);
    endtask

    initial begin
        int w;
        logic rdy;
        logic [1:0] exp_g;
        rst_n           = 1'b0;
        src_valid_i     = 2'b00;
        src_last_i      = 2'b00;
        src_data_i      = 64'd0;
        dst_ready_i     = 1'b0;
        credit_return_i = 1'b0;

        // ---------------- single packet ----------------
        do_reset();
        check_reset("rst0");
        drive(2'b01, 2'b00, 32'h11, 32'h0, 1'b1, 1'b0);
        check_eq("sp_arb_dvalid", 32'(dst_valid_o), 32'd0);
        check_eq("sp_arb_sready", 32'(src_ready_o), 32'd0);
        check_eq("sp_arb_grant",  32'(grant_o),     32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b01, {1'b0, (i == 6)}, 32'h11 + 32'(i), 32'h0, 1'b1, 1'b0);
            check_eq("sp_grant",  32'(grant_o),     32'h1);
            check_eq("sp_dvalid", 32'(dst_valid_o), 32'd1);
            check_eq("sp_data",   dst_data_o,       32'h11 + 32'(i));
            check_eq("sp_last",   32'(dst_last_o),  32'(i == 6));
            check_eq("sp_sready", 32'(src_ready_o), 32'h1);
            check_eq("sp_credit", 32'(credit_cnt_o), 32'd3);
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("sp_end_grant",  32'(grant_o),      32'd0);
        check_eq("sp_end_busy",   32'(busy_o),       32'd0);
        check_eq("sp_end_credit", 32'(credit_cnt_o), 32'd3);
        check_eq("sp_end_lenerr", 32'(len_err_o),    32'd0);

        // ---------------- round-robin fairness ----------------
        do_reset();
        for (int p = 0; p < 4; p++) begin
            exp_g = (p % 2 == 0) ? 2'b01 : 2'b10;
            drive(2'b11, 2'b00, 32'hA0, 32'hB0, 1'b1, 1'b0);
            check_eq("rr_arb_busy",   32'(busy_o),       32'd0);
            check_eq("rr_arb_credit", 32'(credit_cnt_o), 32'(4 - p));
            for (int i = 0; i < 7; i++) begin
                drive(2'b11, (i == 6) ? 2'b11 : 2'b00, 32'hA0 + 32'(i), 32'hB0 + 32'(i), 1'b1, 1'b0);
                check_eq("rr_grant",  32'(grant_o),     32'(exp_g));
                check_eq("rr_data",   dst_data_o,       ((p % 2 == 0) ? 32'hA0 : 32'hB0) + 32'(i));
                check_eq("rr_last",   32'(dst_last_o),  32'(i == 6));
                check_eq("rr_sready", 32'(src_ready_o), 32'(exp_g));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b00, 32'hA0, 32'hB0, 1'b1, 1'b0);
            check_eq("rr_stall_busy",   32'(busy_o),       32'd0);
            check_eq("rr_stall_grant",  32'(grant_o),      32'd0);
            check_eq("rr_stall_dvalid", 32'(dst_valid_o),  32'd0);
            check_eq("rr_stall_credit", 32'(credit_cnt_o), 32'd0);
        end

        // ---------------- credit flow ----------------
        drive(2'b11, 2'b00, 32'hC0, 32'hD0, 1'b1, 1'b1);
        check_eq("cr_ret_busy",   32'(busy_o),       32'd0);
        check_eq("cr_ret_credit", 32'(credit_cnt_o), 32'd0);
        drive(2'b11, 2'b00, 32'hC0, 32'hD0, 1'b1, 1'b0);
        check_eq("cr_one_credit", 32'(credit_cnt_o), 32'd1);
        check_eq("cr_one_busy",   32'(busy_o),       32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, (i == 6) ? 2'b11 : 2'b00, 32'hC0 + 32'(i), 32'hD0 + 32'(i), 1'b1, 1'b0);
            check_eq("cr_grant", 32'(grant_o), 32'h1);
            check_eq("cr_data",  dst_data_o,   32'hC0 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 2'b00, 32'hC0, 32'hD0, 1'b1, 1'b0);
            check_eq("cr_stall_busy",   32'(busy_o),       32'd0);
            check_eq("cr_stall_credit", 32'(credit_cnt_o), 32'd0);
        end
        // Grant and return in the same cycle.
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        check_eq("cr_sim_pre", 32'(credit_cnt_o), 32'd0);
        drive(2'b10, 2'b00, 32'h0, 32'hE0, 1'b1, 1'b1);
        check_eq("cr_sim_arb_credit", 32'(credit_cnt_o), 32'd1);
        check_eq("cr_sim_arb_busy",   32'(busy_o),       32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b10, (i == 6) ? 2'b10 : 2'b00, 32'h0, 32'hE0 + 32'(i), 1'b1, 1'b0);
            check_eq("cr_sim_credit", 32'(credit_cnt_o), 32'd1);
            check_eq("cr_sim_grant",  32'(grant_o),      32'h2);
            check_eq("cr_sim_data",   dst_data_o,        32'hE0 + 32'(i));
        end
        // Refill to the ceiling, then three more returns must be ignored.
        for (int i = 0; i < 6; i++) begin
            drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
            check_eq("cr_sat", 32'(credit_cnt_o), (i < 3) ? 32'(1 + i) : 32'd4);
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("cr_sat_final", 32'(credit_cnt_o), 32'd4);

        // ---------------- backpressure ----------------
        drive(2'b01, 2'b00, 32'h50, 32'h0, 1'b0, 1'b0);
        check_eq("bp_arb_busy", 32'(busy_o), 32'd0);
        w = 0;
        for (int c = 0; c < 8; c++) begin
            rdy = (c % 2 == 1);
            drive(2'b01, {1'b0, (w == 3)}, 32'h50 + 32'(w), 32'h0, rdy, 1'b0);
            check_eq("bp_dvalid", 32'(dst_valid_o), 32'd1);
            check_eq("bp_data",   dst_data_o,       32'h50 + 32'(w));
            check_eq("bp_last",   32'(dst_last_o),  32'(w == 3));
            check_eq("bp_sready", 32'(src_ready_o), rdy ? 32'h1 : 32'h0);
            if (rdy) w++;
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_end_busy",   32'(busy_o),       32'd0);
        check_eq("bp_end_credit", 32'(credit_cnt_o), 32'd3);
        check_eq("bp_end_lenerr", 32'(len_err_o),    32'd0);

        // ---------------- length watchdog ----------------
        drive(2'b10, 2'b00, 32'h0, 32'h90, 1'b1, 1'b0);
        check_eq("wd_arb_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b10, 2'b00, 32'h0, 32'h90 + 32'(i), 1'b1, 1'b0);
            check_eq("wd_grant",  32'(grant_o),    32'h2);
            check_eq("wd_data",   dst_data_o,      32'h90 + 32'(i));
            check_eq("wd_last",   32'(dst_last_o), 32'(i == 6));
            check_eq("wd_lenerr", 32'(len_err_o),  32'd0);
        end
        drive(2'b10, 2'b00, 32'h0, 32'h97, 1'b1, 1'b0);
        check_eq("wd_bub_busy",   32'(busy_o),       32'd0);
        check_eq("wd_bub_dvalid", 32'(dst_valid_o),  32'd0);
        check_eq("wd_bub_lenerr", 32'(len_err_o),    32'd1);
        check_eq("wd_bub_credit", 32'(credit_cnt_o), 32'd2);
        for (int i = 7; i < 9; i++) begin
            drive(2'b10, 2'b00, 32'h0, 32'h90 + 32'(i), 1'b1, 1'b0);
            check_eq("wd2_grant",  32'(grant_o),      32'h2);
            check_eq("wd2_data",   dst_data_o,        32'h90 + 32'(i));
            check_eq("wd2_last",   32'(dst_last_o),   32'd0);
            check_eq("wd2_credit", 32'(credit_cnt_o), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
            check_eq("wd_hold_grant",  32'(grant_o),     32'h2);
            check_eq("wd_hold_busy",   32'(busy_o),      32'd1);
            check_eq("wd_hold_dvalid", 32'(dst_valid_o), 32'd0);
            check_eq("wd_hold_lenerr", 32'(len_err_o),   32'd1);
        end

        // ---------------- reset mid-packet ----------------
        do_reset();
        check_reset("rst1");
        drive(2'b01, 2'b00, 32'h60, 32'h70, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 2'b00, 32'h60 + 32'(i), 32'h70, 1'b1, 1'b0);
            check_eq("rm_data", dst_data_o, 32'h60 + 32'(i));
        end
        do_reset();
        check_reset("rst_mid");
        drive(2'b11, 2'b00, 32'h60, 32'h70, 1'b1, 1'b0);
        check_eq("rm_arb_busy", 32'(busy_o), 32'd0);
        drive(2'b11, 2'b00, 32'h60, 32'h70, 1'b1, 1'b0);
        check_eq("rm_ptr_grant", 32'(grant_o), 32'h1);
        check_eq("rm_ptr_data",  dst_data_o,   32'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
